mips_dmem_bridge: RTL and testbench
===================================

// Module: mips_dmem_bridge
// PURPOSE
//  Sits between the core's data SRAM port (memory-stage access: addr, wdata, byte
//  sel, write flag) and a request/ack SRAM-like data bus. Turns each memory-stage
//  access into one bus transaction and stalls the core until the data returns.
//  Maps kseg0/kseg1 virtual addresses to physical addresses.
// PARAMETERS
//  ADDR_MAP_EN  1  1: VA 0x8000_0000..0xBFFF_FFFF -> PA = VA & 0x1FFF_FFFF; 0: PA = VA
// PORTS
//  clk            in   1   clock, all state updates on rising edge
//  rst            in   1   asynchronous, active-low reset
//  mem_enM        in   1   core: memory-stage access valid this cycle
//  memwriteM      in   1   core: 1=store, 0=load
//  selM           in   4   core: byte lane enables
//  aluoutM        in   32  core: virtual byte address
//  writedataM     in   32  core: store data, already lane-aligned
//  readdataM      out  32  core: load data, valid in the cycle stallM falls
//  stallM         out  1   core: freeze the whole pipeline while high
//  data_req       out  1   bus: request valid
//  data_wr        out  1   bus: 1=write
//  data_size      out  2   bus: 0=byte, 1=half, 2=word
//  data_addr      out  32  bus: physical address
//  data_wdata     out  32  bus: write data
//  data_addr_ok   in   1   bus: request accepted this cycle
//  data_data_ok   in   1   bus: response or write-complete this cycle
//  data_rdata     in   32  bus: read data, valid with data_data_ok
// BEHAVIOUR
//  Reset (rst=0, async): state=IDLE; data_req=0, stallM=0, readdataM=0, other
//   bus outputs 0. Any in-flight transaction is dropped; the bus side is reset too.
//  FSM states: IDLE, REQ, WAIT, DONE.
//   IDLE: mem_enM=1 -> REQ. Latch addr, wr, size and wdata into registers.
//     stallM is asserted combinationally in this same cycle.
//   REQ: data_req=1, request fields come from the latch.
//     addr_ok=1 & data_ok=0 -> WAIT
//     addr_ok=1 & data_ok=1 (same cycle) -> DONE, capture rdata
//     addr_ok=0 -> stay in REQ, fields held stable
//   WAIT: data_req=0. data_ok=1 -> DONE, readdataM<=data_rdata (loads only).
//     data_ok=0 -> stay in WAIT.
//   DONE: stallM=0 and readdataM is held, so the core advances this cycle.
//     The same access is still on the core port, so no new request is issued.
//     Next state is always IDLE.
//  stallM = (IDLE & mem_enM) | REQ | WAIT. It is low in DONE and in IDLE with no access.
//  Latency: the minimum load is 3 cycles of stall-or-done (IDLE detect, REQ with
//   same-cycle addr_ok/data_ok, DONE). Back-to-back accesses need one IDLE cycle between them.
//  data_size from selM: 0001/0010/0100/1000 -> 0; 0011/1100 -> 1; 1111 -> 2.
//   Any other nonzero pattern -> 2. selM=0000 with mem_enM=1 is still issued as
//   size 2. The core never produces these two cases.
//  data_addr = aluoutM passed through unchanged, low 2 bits kept; alignment is the
//   core's job. Mapping applies only when ADDR_MAP_EN=1 and VA[31:30]==2'b10.
//  Stores: readdataM keeps its old value. data_ok ends the write the same way as a load.
//  data_ok seen in IDLE or DONE (spurious): ignored. data_ok in REQ without addr_ok: ignored.
//  Only one transaction is outstanding at a time; requests are never pipelined.
// TESTING
//  1 Load, addr 0xBFC0_0010, sel 1111; addr_ok at cycle 1, data_ok at cycle 3,
//    rdata 0x1234_5678 -> data_addr 0x1FC0_0010, size 2, wr 0; stallM high for
//    cycles 0-3; readdataM 0x1234_5678 at cycle 4 with stallM low.
//  2 Store byte, addr 0x8000_0003, sel 1000, wdata 0xAB00_0000, addr_ok and data_ok
//    in the same cycle -> data_addr 0x0000_0003, size 0, wr 1; REQ->DONE; readdataM unchanged.
//  3 Hold addr_ok low for 5 cycles -> data_req and all request fields stable,
//    stallM high throughout; only one request is accepted.
//  4 ADDR_MAP_EN=0, addr 0xA000_0040 -> data_addr 0xA000_0040.
//    With ADDR_MAP_EN=1, addr 0x0000_1000 -> data_addr unchanged (useg, no mapping).
//  5 Two back-to-back loads, mem_enM held high -> exactly 2 bus requests, with one
//    IDLE cycle between DONE and the second REQ.
//  6 Pull rst low while in WAIT -> all outputs 0 immediately (async);
//    a data_ok after reset release is ignored.

Source files
------------

// File: rtl/mips_dmem_bridge.sv
// Bridges the core's memory-stage data port onto a request/ack SRAM-like bus.
// Each access becomes one bus transaction, and the core is stalled until that transaction completes.
module mips_dmem_bridge #(
  parameter bit ADDR_MAP_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_enM,
  input  logic        memwriteM,
  input  logic [3:0]  selM,
  input  logic [31:0] aluoutM,
  input  logic [31:0] writedataM,
  output logic [31:0] readdataM,
  output logic        stallM,
  output logic        data_req,
  output logic        data_wr,
  output logic [1:0]  data_size,
  output logic [31:0] data_addr,
  output logic [31:0] data_wdata,
  input  logic        data_addr_ok,
  input  logic        data_data_ok,
  input  logic [31:0] data_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

  state_t      r_state;
  logic        r_req;
  logic        r_wr;
  logic [1:0]  r_size;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_rdata;

  logic [1:0]  w_size;
  logic [31:0] w_paddr;

  always_comb begin
    case (selM)
      4'b0001, 4'b0010, 4'b0100, 4'b1000: w_size = 2'd0;
      4'b0011, 4'b1100:                   w_size = 2'd1;
      default:                            w_size = 2'd2;
    endcase
    // kseg0/kseg1 fold onto the low 512 MB of physical space
    if (ADDR_MAP_EN && aluoutM[31:30] == 2'b10)
      w_paddr = {3'b000, aluoutM[28:0]};
    else
      w_paddr = aluoutM;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_req   <= 1'b0;
      r_wr    <= 1'b0;
      r_size  <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (mem_enM) begin
            r_state <= S_REQ;
            r_req   <= 1'b1;
            r_wr    <= memwriteM;
            r_size  <= w_size;
            r_addr  <= w_paddr;
            r_wdata <= writedataM;
          end
        end
        S_REQ: begin
          if (data_addr_ok) begin
            r_req <= 1'b0;
            if (data_data_ok) begin
              r_state <= S_DONE;
              if (!r_wr) r_rdata <= data_rdata;
            end else begin
              r_state <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (data_data_ok) begin
            r_state <= S_DONE;
            if (!r_wr) r_rdata <= data_rdata;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Gated by reset so the core sees no stall while the bridge is held in reset
  assign stallM = rst & ((r_state == S_IDLE && mem_enM) ||
                         r_state == S_REQ || r_state == S_WAIT);

  assign readdataM  = r_rdata;
  assign data_req   = r_req;
  assign data_wr    = r_wr;
  assign data_size  = r_size;
  assign data_addr  = r_addr;
  assign data_wdata = r_wdata;

endmodule

// File: tb/tb_mips_dmem_bridge.sv
// Randomized bench for mips_dmem_bridge: the core and bus sides are driven on a known timeline.
// Each cycle is checked against transaction-level expectations derived from the address, size and handshake rules.
module tb_mips_dmem_bridge;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        mem_enM = 1'b0;
  logic        memwriteM = 1'b0;
  logic [3:0]  selM = '0;
  logic [31:0] aluoutM = '0;
  logic [31:0] writedataM = '0;
  logic        data_addr_ok = 1'b0;
  logic        data_data_ok = 1'b0;
  logic [31:0] data_rdata = '0;

  logic [31:0] readdataM, readdataM_0;
  logic        stallM, stallM_0;
  logic        data_req, data_req_0;
  logic        data_wr, data_wr_0;
  logic [1:0]  data_size, data_size_0;
  logic [31:0] data_addr, data_addr_0;
  logic [31:0] data_wdata, data_wdata_0;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  logic [31:0] exp_rd  = '0;

  always #5 clk = ~clk;

  mips_dmem_bridge #(.ADDR_MAP_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .mem_enM(mem_enM), .memwriteM(memwriteM), .selM(selM),
    .aluoutM(aluoutM), .writedataM(writedataM), .readdataM(readdataM), .stallM(stallM),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
    .data_rdata(data_rdata)
  );

  mips_dmem_bridge #(.ADDR_MAP_EN(1'b0)) dut0 (
    .clk(clk), .rst(rst), .mem_enM(mem_enM), .memwriteM(memwriteM), .selM(selM),
    .aluoutM(aluoutM), .writedataM(writedataM), .readdataM(readdataM_0), .stallM(stallM_0),
    .data_req(data_req_0), .data_wr(data_wr_0), .data_size(data_size_0), .data_addr(data_addr_0),
    .data_wdata(data_wdata_0), .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
    .data_rdata(data_rdata)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_pa(input logic [31:0] va, input bit map);
    if (map && va >= 32'h8000_0000 && va <= 32'hBFFF_FFFF) return va & 32'h1FFF_FFFF;
    return va;
  endfunction

  function automatic logic [1:0] ref_size(input logic [3:0] sel);
    if ($countones(sel) == 1) return 2'd0;
    if (sel == 4'b0011 || sel == 4'b1100) return 2'd1;
    return 2'd2;
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // One access: IDLE detect, (a_dly+1) REQ cycles, d_dly WAIT cycles, then DONE.
  task automatic do_access(input logic wr, input logic [3:0] sel, input logic [31:0] va,
                           input logic [31:0] wd, input int a_dly, input int d_dly,
                           input logic [31:0] rd);
    mem_enM = 1'b1; memwriteM = wr; selM = sel; aluoutM = va; writedataM = wd;
    data_addr_ok = 1'b0; data_data_ok = 1'($urandom_range(0, 1)); data_rdata = $urandom;
    @(negedge clk);
    check("idle_stall", 32'(stallM), 32'd1);
    check("idle_req", 32'(data_req), 32'd0);
    next_cycle();
    for (int i = 0; i <= a_dly; i++) begin
      data_addr_ok = (i == a_dly);
      data_data_ok = (i == a_dly) ? (d_dly == 0) : 1'($urandom_range(0, 1));
      data_rdata   = (i == a_dly && d_dly == 0) ? rd : $urandom;
      @(negedge clk);
      check("req_stall", 32'(stallM), 32'd1);
      check("req_valid", 32'(data_req), 32'd1);
      check("req_wr", 32'(data_wr), 32'(wr));
      check("req_size", 32'(data_size), 32'(ref_size(sel)));
      check("req_addr", data_addr, ref_pa(va, 1'b1));
      check("req_wdata", data_wdata, wd);
      check("req_addr_nomap", data_addr_0, ref_pa(va, 1'b0));
      next_cycle();
    end
    for (int i = 1; i <= d_dly; i++) begin
      data_addr_ok = 1'b0;
      data_data_ok = (i == d_dly);
      data_rdata   = (i == d_dly) ? rd : $urandom;
      @(negedge clk);
      check("wait_stall", 32'(stallM), 32'd1);
      check("wait_req", 32'(data_req), 32'd0);
      next_cycle();
    end
    data_addr_ok = 1'b0; data_data_ok = 1'($urandom_range(0, 1)); data_rdata = $urandom;
    if (!wr) exp_rd = rd;
    @(negedge clk);
    check("done_stall", 32'(stallM), 32'd0);
    check("done_req", 32'(data_req), 32'd0);
    check("done_rdata", readdataM, exp_rd);
    next_cycle();
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      mem_enM = 1'b0; data_addr_ok = 1'b0;
      data_data_ok = 1'($urandom_range(0, 1)); data_rdata = $urandom;
      @(negedge clk);
      check("idle_nostall", 32'(stallM), 32'd0);
      check("idle_noreq", 32'(data_req), 32'd0);
      check("idle_rdata", readdataM, exp_rd);
      next_cycle();
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_stall"}, 32'(stallM), 32'd0);
    check({tag, "_req"}, 32'(data_req), 32'd0);
    check({tag, "_wr"}, 32'(data_wr), 32'd0);
    check({tag, "_size"}, 32'(data_size), 32'd0);
    check({tag, "_addr"}, data_addr, 32'd0);
    check({tag, "_wdata"}, data_wdata, 32'd0);
    check({tag, "_rdata"}, readdataM, 32'd0);
  endtask

  initial begin
    #200_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0] sels [9] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'hC, 4'hF, 4'h5, 4'h0};
    mem_enM = 1'b1;
    #3;
    check_all_zero("reset");
    next_cycle();
    rst = 1'b1;
    mem_enM = 1'b0;
    idle_cycles(2);

    do_access(1'b0, 4'hF, 32'hBFC0_0010, $urandom, 0, 2, 32'h1234_5678);
    idle_cycles(1);
    do_access(1'b1, 4'h8, 32'h8000_0003, 32'hAB00_0000, 0, 0, $urandom);
    idle_cycles(1);
    do_access(1'b0, 4'h3, 32'h9000_0102, $urandom, 5, 1, $urandom);
    do_access(1'b0, 4'hF, 32'hA000_0040, $urandom, 1, 0, $urandom);
    do_access(1'b0, 4'hF, 32'h0000_1000, $urandom, 0, 3, $urandom);
    do_access(1'b0, 4'hF, 32'h0000_2000, $urandom, 0, 0, $urandom);
    idle_cycles(1);

    // Reset while a store sits in WAIT
    mem_enM = 1'b1; memwriteM = 1'b1; selM = 4'hF; aluoutM = 32'h9000_0010;
    writedataM = 32'hDEAD_BEEF; data_addr_ok = 1'b0; data_data_ok = 1'b0;
    next_cycle();
    data_addr_ok = 1'b1;
    next_cycle();
    data_addr_ok = 1'b0;
    @(negedge clk);
    check("pre_rst_stall", 32'(stallM), 32'd1);
    check("pre_rst_addr", data_addr, 32'h1000_0010);
    #1 rst = 1'b0;
    #1 check_all_zero("async_rst");
    mem_enM = 1'b0;
    next_cycle();
    rst = 1'b1;
    exp_rd = '0;
    data_data_ok = 1'b1; data_rdata = $urandom;
    @(negedge clk);
    check("post_rst_stall", 32'(stallM), 32'd0);
    check("post_rst_req", 32'(data_req), 32'd0);
    check("post_rst_rdata", readdataM, 32'd0);
    next_cycle();
    data_data_ok = 1'b0;
    idle_cycles(2);

    for (int n = 0; n < 80; n++) begin
      logic [31:0] va;
      va = $urandom;
      do_access(1'($urandom_range(0, 1)), sels[$urandom_range(0, 8)], va, $urandom,
                int'($urandom_range(0, 4)), int'($urandom_range(0, 4)), $urandom);
      idle_cycles(int'($urandom_range(0, 2)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
